tue_apb_seq: RTL and testbench
==============================

# tue_apb_seq

Control-plane APB master that sits directly upstream of the Table Update Engine. It accepts one table-entry descriptor at a time over a valid/ready handshake, serialises it into the TUE register-file write sequence, and fires the commit. It then polls TUE status until the transaction completes, returning a one-cycle response with an error flag. The whole block runs in the `clk_ctrl` domain.

## Interface
Parameters:
- `KEY_W`, default `MAU_TCAM_KEY_W` (512): key/mask width; must be a multiple of 32.
- `POLL_TIMEOUT`, default 1024: maximum number of `clk_ctrl` cycles spent in the poll phase before declaring an error.

Ports:
- `clk_ctrl` — in — 1 — control clock.
- `rst_ctrl` — in — 1 — asynchronous, active-high reset.
- `desc_valid` — in — 1 — descriptor offered.
- `desc_ready` — out — 1 — block idle; descriptor accepted on `desc_valid && desc_ready`.
- `desc_cmd` — in — 2 — TUE command (0=INSERT, 1=DELETE, 2=MODIFY, 3=FLUSH).
- `desc_stage` — in — 5 — target MAU stage; 5'h1F selects the parser.
- `desc_table_id` — in — 16 — entry address/pointer.
- `desc_key`, `desc_mask` — in — KEY_W — TCAM key and mask.
- `desc_action_id` — in — 16 — action ID.
- `desc_action_params` — in — 96 — action parameters.
- `rsp_valid` — out — 1 — one-cycle completion pulse.
- `rsp_err` — out — 1 — qualifies `rsp_valid`; 1 = failed.
- `busy` — out — 1 — not idle.
- `m_psel`, `m_penable`, `m_pwrite` — out — 1 each — APB master control.
- `m_paddr` — out — 12 — APB address; uses the `TUE_REG_*` constants from `rv_p4_pkg`.
- `m_pwdata` — out — 32 — write data.
- `m_prdata` — in — 32 — read data.
- `m_pready`, `m_pslverr` — in — 1 each — APB slave response.

## Operation
States: IDLE → WRITE → POLL_BUSY → POLL_IDLE → RESP → IDLE.

IDLE
- `desc_ready = ~rst_ctrl`.
- On accept, latch all descriptor fields into holding registers, clear the write index `widx` (6 bits) and go to WRITE.
- Descriptor inputs are ignored outside IDLE.

WRITE: 40 APB write transfers in fixed order, `widx` 0..39.
- `widx` 0: CMD, data `{30'b0,cmd}`.
- `widx` 1: TABLE_ID, data `{16'b0,table_id}`.
- `widx` 2: STAGE, data `{27'b0,stage}`.
- `widx` 3..18: KEY_0 + 4·k, data `key[32k+:32]`, k = 0..15.
- `widx` 19..34: MASK_0 + 4·k, data `mask[32k+:32]`.
- `widx` 35: ACTION_ID, data `{16'b0,action_id}`.
- `widx` 36..38: ACTION_P0..P2, data `params[31:0]`, `params[63:32]`, `params[95:64]`.
- `widx` 39: COMMIT, data 32'h1.
- After the COMMIT transfer completes, go to POLL_BUSY.
- The same sequence is used for all commands, including FLUSH.

POLL_BUSY: repeated APB reads of STATUS.
- Read value 1 or 2 → POLL_IDLE.
- Read value 0 → keep polling (TUE not yet started).
- Read value 3 → RESP with error.

POLL_IDLE: repeated APB reads of STATUS.
- Read value 0 → RESP, OK.
- Read value 1 or 2 → keep polling.
- Read value 3 → RESP with error.

Error sources:
- Any transfer completing with `m_pslverr=1` aborts immediately to RESP with error; no further writes are issued.
- Timeout counter (`clog2(POLL_TIMEOUT+1)` bits) clears on entering POLL_BUSY and increments every cycle in either poll state. Reaching `POLL_TIMEOUT` goes to RESP with error. A transfer already in ACCESS at that moment completes first; its data is ignored.

RESP
- `rsp_valid=1` for exactly one cycle, `rsp_err` per the outcome, then IDLE.

`busy = (state != IDLE)`.

## Timing
APB transfer:
- SETUP cycle: `psel=1`, `penable=0`, with `paddr`/`pwrite`/`pwdata` valid.
- ACCESS cycles: `psel=1`, `penable=1` until `m_pready=1`.
- The next SETUP starts in the cycle immediately after completion, so `psel` stays high. There is no idle cycle between back-to-back transfers.
- Address and data stay stable from SETUP through completion.

Latency:
- Accept cycle N → first SETUP at N+1.
- With `pready` tied high, each transfer takes 2 cycles, so COMMIT completes at N+80.
- First STATUS SETUP at N+81.

All APB outputs are registered.

Reset:
- Values: `m_psel=0`, `m_penable=0`, `m_pwrite=0`, `m_paddr=0`, `m_pwdata=0`, `rsp_valid=0`, `rsp_err=0`, `busy=0`, `desc_ready=0`; state = IDLE.
- Reset asserted mid-sequence drops `psel`/`penable` immediately, with no partial-transfer completion and no response.
- `desc_ready` goes to 1 in the first cycle after deassertion.

`rsp_valid` and the `desc_ready` rise never overlap; RESP always precedes IDLE by one cycle.

## Test plan
- **INSERT, `pready` tied 1.** Stimulus: stage=3, table_id=16'h0042, key word k = 32'hA000_0000+k, mask all ones. Slave returns STATUS 0, 1, 1, 2, 0. Required: exactly 40 writes in the listed order with the listed data, the COMMIT write at N+79..N+80, then a single `rsp_valid` with `rsp_err=0`.
- **Wait states.** Stimulus: `pready` low for 3 cycles on every transfer. Required: addr/data stable across each ACCESS, each transfer takes 5 cycles, same write order, OK response.
- **pslverr.** Stimulus: `m_pslverr=1` on the KEY_5 write (widx 8). Required: no further transfers, `rsp_valid` with `rsp_err=1` the next cycle, then `desc_ready=1`.
- **Timeout and error status.** Case 1: STATUS stuck at 1 with `POLL_TIMEOUT=64`. Required: `rsp_err=1` within 64 cycles plus the in-flight transfer. Case 2: STATUS reads 3. Required: immediate `rsp_err=1`.
- **Descriptor handshake.** Stimulus: `desc_valid` held high with changing fields while busy. Required: fields are ignored, `desc_ready=0` throughout, and the second descriptor is accepted only in IDLE after RESP.
- **Mid-sequence reset.** Stimulus: assert `rst_ctrl` during the MASK writes. Required: `psel`/`penable` are 0 in the same cycle, no `rsp_valid`, and a fresh descriptor afterwards restarts at widx 0.

Source files
------------

// File: rtl/tue_apb_seq_if.sv
// Descriptor handshake, response and APB master signal bundle for tue_apb_seq.
// The master modport is the sequencer's view; slave is the environment's view.
interface tue_apb_seq_if #(
    parameter int unsigned KEY_W = 512
);
    logic             desc_valid;
    logic             desc_ready;
    logic [1:0]       desc_cmd;
    logic [4:0]       desc_stage;
    logic [15:0]      desc_table_id;
    logic [KEY_W-1:0] desc_key;
    logic [KEY_W-1:0] desc_mask;
    logic [15:0]      desc_action_id;
    logic [95:0]      desc_action_params;
    logic             rsp_valid;
    logic             rsp_err;
    logic             busy;
    logic             m_psel;
    logic             m_penable;
    logic             m_pwrite;
    logic [11:0]      m_paddr;
    logic [31:0]      m_pwdata;
    logic [31:0]      m_prdata;
    logic             m_pready;
    logic             m_pslverr;

    modport master (
        input  desc_valid, desc_cmd, desc_stage, desc_table_id, desc_key, desc_mask,
        input  desc_action_id, desc_action_params, m_prdata, m_pready, m_pslverr,
        output desc_ready, rsp_valid, rsp_err, busy,
        output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
    );

    modport slave (
        output desc_valid, desc_cmd, desc_stage, desc_table_id, desc_key, desc_mask,
        output desc_action_id, desc_action_params, m_prdata, m_pready, m_pslverr,
        input  desc_ready, rsp_valid, rsp_err, busy,
        input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
    );
endinterface

// File: rtl/tue_apb_seq.sv
// APB master that writes one TUE table-entry descriptor into the register file,
// commits it, polls STATUS until done and returns a one-cycle response.
module tue_apb_seq #(
    parameter int unsigned KEY_W        = 512,
    parameter int unsigned POLL_TIMEOUT = 1024
) (
    input logic           clk_ctrl,
    input logic           rst_ctrl,
    tue_apb_seq_if.master bus
);
    localparam logic [11:0] TueRegCmd      = 12'h000;
    localparam logic [11:0] TueRegTableId  = 12'h004;
    localparam logic [11:0] TueRegStage    = 12'h008;
    localparam logic [11:0] TueRegActionId = 12'h00C;
    localparam logic [11:0] TueRegActionP0 = 12'h010;
    localparam logic [11:0] TueRegCommit   = 12'h01C;
    localparam logic [11:0] TueRegStatus   = 12'h020;
    localparam logic [11:0] TueRegKey0     = 12'h100;
    localparam logic [11:0] TueRegMask0    = 12'h200;

    localparam int unsigned NumWords  = KEY_W / 32;
    localparam int unsigned KeyFirst  = 3;
    localparam int unsigned MaskFirst = KeyFirst + NumWords;
    localparam int unsigned ActFirst  = MaskFirst + NumWords;
    localparam int unsigned NumWrites = ActFirst + 5;
    localparam int unsigned IdxW      = $clog2(NumWrites);
    localparam int unsigned TmoW      = $clog2(POLL_TIMEOUT + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWrites - 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(POLL_TIMEOUT);

    typedef enum logic [2:0] {StIdle, StWrite, StPollBusy, StPollIdle, StResp} state_e;

    state_e           state_q;
    logic [4:0]       stage_q;
    logic [15:0]      table_id_q;
    logic [15:0]      action_id_q;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] mask_q;
    logic [95:0]      params_q;
    logic [IdxW-1:0]  widx_q;
    logic [TmoW-1:0]  tcnt_q;
    logic             psel_q;
    logic             penable_q;
    logic             pwrite_q;
    logic [11:0]      paddr_q;
    logic [31:0]      pwdata_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;

    logic [IdxW-1:0]  nidx;
    int unsigned      ni;
    logic [11:0]      nxt_addr;
    logic [31:0]      nxt_data;
    logic             xfer_done;
    logic             st_done;
    logic             st_err;
    logic             st_active;

    // Address/data of the write that follows the current one; widx 0 is loaded at accept.
    always_comb begin
        nidx     = widx_q + IdxW'(1);
        ni       = 32'(nidx);
        nxt_addr = TueRegCommit;
        nxt_data = 32'h1;
        if (ni == 1) begin
            nxt_addr = TueRegTableId;
            nxt_data = {16'b0, table_id_q};
        end else if (ni == 2) begin
            nxt_addr = TueRegStage;
            nxt_data = {27'b0, stage_q};
        end else if (ni < MaskFirst) begin
            nxt_addr = TueRegKey0 + 12'(4 * (ni - KeyFirst));
            nxt_data = 32'(key_q >> (32 * (ni - KeyFirst)));
        end else if (ni < ActFirst) begin
            nxt_addr = TueRegMask0 + 12'(4 * (ni - MaskFirst));
            nxt_data = 32'(mask_q >> (32 * (ni - MaskFirst)));
        end else if (ni == ActFirst) begin
            nxt_addr = TueRegActionId;
            nxt_data = {16'b0, action_id_q};
        end else if (ni < NumWrites - 1) begin
            nxt_addr = TueRegActionP0 + 12'(4 * (ni - ActFirst - 1));
            nxt_data = 32'(params_q >> (32 * (ni - ActFirst - 1)));
        end
    end

    always_comb begin
        xfer_done = psel_q && penable_q && bus.m_pready;
        st_done   = (bus.m_prdata == 32'd0);
        st_err    = (bus.m_prdata == 32'd3);
        st_active = (bus.m_prdata == 32'd1) || (bus.m_prdata == 32'd2);
    end

    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            table_id_q  <= '0;
            action_id_q <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            params_q    <= '0;
            widx_q      <= '0;
            tcnt_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.desc_valid) begin
                        stage_q     <= bus.desc_stage;
                        table_id_q  <= bus.desc_table_id;
                        action_id_q <= bus.desc_action_id;
                        key_q       <= bus.desc_key;
                        mask_q      <= bus.desc_mask;
                        params_q    <= bus.desc_action_params;
                        widx_q      <= '0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b1;
                        paddr_q     <= TueRegCmd;
                        pwdata_q    <= {30'b0, bus.desc_cmd};
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    if (!penable_q) begin
                        penable_q <= 1'b1;
                    end else if (xfer_done) begin
                        penable_q <= 1'b0;
                        if (bus.m_pslverr) begin
                            psel_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= StResp;
                        end else if (widx_q == LastIdx) begin
                            pwrite_q <= 1'b0;
                            paddr_q  <= TueRegStatus;
                            pwdata_q <= '0;
                            tcnt_q   <= '0;
                            state_q  <= StPollBusy;
                        end else begin
                            widx_q   <= nidx;
                            paddr_q  <= nxt_addr;
                            pwdata_q <= nxt_data;
                        end
                    end
                end
                StPollBusy, StPollIdle: begin
                    if (tcnt_q != TmoMax) begin
                        tcnt_q <= tcnt_q + TmoW'(1);
                    end
                    // A timeout is only acted on at a transfer boundary so APB stays legal.
                    if (!penable_q) begin
                        penable_q <= 1'b1;
                    end else if (xfer_done) begin
                        penable_q <= 1'b0;
                        if (bus.m_pslverr || (tcnt_q == TmoMax) || st_err) begin
                            psel_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= StResp;
                        end else if ((state_q == StPollBusy) && st_active) begin
                            state_q <= StPollIdle;
                        end else if ((state_q == StPollIdle) && st_done) begin
                            psel_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.desc_ready = (state_q == StIdle) && !rst_ctrl;
    assign bus.busy       = (state_q != StIdle);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.m_psel     = psel_q;
    assign bus.m_penable  = penable_q;
    assign bus.m_pwrite   = pwrite_q;
    assign bus.m_paddr    = paddr_q;
    assign bus.m_pwdata   = pwdata_q;
endmodule

// File: tb/tb_tue_apb_seq.sv
// Bench for tue_apb_seq: APB slave model with wait states, STATUS script and error injection,
// and a write-list reference built directly from the register map.
module tb_tue_apb_seq;
    localparam int unsigned KeyW = 512;
    localparam int unsigned Tmo  = 64;
    localparam int unsigned NWr  = 40;

    localparam logic [11:0] RegCmd      = 12'h000;
    localparam logic [11:0] RegTableId  = 12'h004;
    localparam logic [11:0] RegStage    = 12'h008;
    localparam logic [11:0] RegActionId = 12'h00C;
    localparam logic [11:0] RegActionP0 = 12'h010;
    localparam logic [11:0] RegCommit   = 12'h01C;
    localparam logic [11:0] RegStatus   = 12'h020;
    localparam logic [11:0] RegKey0     = 12'h100;
    localparam logic [11:0] RegMask0    = 12'h200;

    logic clk_ctrl = 1'b0;
    logic rst_ctrl = 1'b1;

    tue_apb_seq_if #(.KEY_W(KeyW)) bus ();

    tue_apb_seq #(
        .KEY_W       (KeyW),
        .POLL_TIMEOUT(Tmo)
    ) dut (
        .clk_ctrl(clk_ctrl),
        .rst_ctrl(rst_ctrl),
        .bus     (bus)
    );

    always #5 clk_ctrl = ~clk_ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk_ctrl) cyc <= cyc + 1;

    // Slave configuration and observation logs
    int          wait_states = 0;
    int          err_at      = -1;
    logic [31:0] status_q[$];
    logic [31:0] status_dflt = 32'd0;
    int          xfer_n      = 0;
    int          unstable    = 0;
    int          overlap     = 0;
    logic [11:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_write[$];
    int          log_setup[$];
    int          log_done[$];
    int          rsp_cyc[$];
    logic        rsp_errq[$];

    // Current descriptor and expected write list
    logic [1:0]      cur_cmd;
    logic [4:0]      cur_stage;
    logic [15:0]     cur_tid;
    logic [KeyW-1:0] cur_key;
    logic [KeyW-1:0] cur_mask;
    logic [15:0]     cur_aid;
    logic [95:0]     cur_params;
    logic [11:0]     exp_addr[NWr];
    logic [31:0]     exp_data[NWr];

    initial begin
        int          acc = 0;
        logic [11:0] s_addr = '0;
        logic [31:0] s_data = '0;
        logic        s_write = 1'b0;
        int          s_setup = 0;
        bus.m_pready  = 1'b0;
        bus.m_prdata  = '0;
        bus.m_pslverr = 1'b0;
        forever begin
            @(negedge clk_ctrl);
            bus.m_pready  = 1'b0;
            bus.m_pslverr = 1'b0;
            bus.m_prdata  = '0;
            if (bus.m_psel && !bus.m_penable) begin
                s_addr  = bus.m_paddr;
                s_data  = bus.m_pwdata;
                s_write = bus.m_pwrite;
                s_setup = cyc;
                acc     = 0;
            end else if (bus.m_psel && bus.m_penable) begin
                if (bus.m_paddr !== s_addr || bus.m_pwdata !== s_data || bus.m_pwrite !== s_write)
                    unstable++;
                if (acc >= wait_states) begin
                    bus.m_pready  = 1'b1;
                    bus.m_pslverr = (xfer_n == err_at);
                    if (!s_write)
                        bus.m_prdata = (status_q.size() != 0) ? status_q.pop_front() : status_dflt;
                    log_addr.push_back(s_addr);
                    log_data.push_back(s_data);
                    log_write.push_back(s_write);
                    log_setup.push_back(s_setup);
                    log_done.push_back(cyc);
                    xfer_n++;
                end
                acc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_ctrl);
            #1;
            if (bus.rsp_valid === 1'b1) begin
                rsp_cyc.push_back(cyc);
                rsp_errq.push_back(bus.rsp_err);
                if (bus.desc_ready !== 1'b0) overlap++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired got running need finished");
        $fatal(1, "watchdog");
    end

    function automatic void build_exp();
        exp_addr[0] = RegCmd;     exp_data[0] = {30'b0, cur_cmd};
        exp_addr[1] = RegTableId; exp_data[1] = {16'b0, cur_tid};
        exp_addr[2] = RegStage;   exp_data[2] = {27'b0, cur_stage};
        for (int k = 0; k < 16; k++) begin
            exp_addr[3 + k]  = RegKey0 + 12'(4 * k);
            exp_data[3 + k]  = 32'(cur_key >> (32 * k));
            exp_addr[19 + k] = RegMask0 + 12'(4 * k);
            exp_data[19 + k] = 32'(cur_mask >> (32 * k));
        end
        exp_addr[35] = RegActionId; exp_data[35] = {16'b0, cur_aid};
        for (int k = 0; k < 3; k++) begin
            exp_addr[36 + k] = RegActionP0 + 12'(4 * k);
            exp_data[36 + k] = 32'(cur_params >> (32 * k));
        end
        exp_addr[39] = RegCommit; exp_data[39] = 32'h1;
    endfunction

    task automatic rand_desc();
        cur_cmd    = 2'($urandom_range(0, 3));
        cur_stage  = 5'($urandom);
        cur_tid    = 16'($urandom);
        cur_aid    = 16'($urandom);
        cur_params = {$urandom, $urandom, $urandom};
        for (int k = 0; k < 16; k++) begin
            cur_key  = {cur_key[KeyW-33:0], 32'($urandom)};
            cur_mask = {cur_mask[KeyW-33:0], 32'($urandom)};
        end
    endtask

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); log_write.delete();
        log_setup.delete(); log_done.delete();
        rsp_cyc.delete(); rsp_errq.delete();
        xfer_n = 0; unstable = 0; overlap = 0;
    endtask

    task automatic send_desc(output int n);
        n = -1;
        @(negedge clk_ctrl);
        bus.desc_valid         = 1'b1;
        bus.desc_cmd           = cur_cmd;
        bus.desc_stage         = cur_stage;
        bus.desc_table_id      = cur_tid;
        bus.desc_key           = cur_key;
        bus.desc_mask          = cur_mask;
        bus.desc_action_id     = cur_aid;
        bus.desc_action_params = cur_params;
        for (int i = 0; i < 300 && n < 0; i++) begin
            #1;
            if (bus.desc_ready === 1'b1) n = cyc;
            @(negedge clk_ctrl);
        end
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk_ctrl);
            #2;
            got = (rsp_cyc.size() != 0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_ctrl);
        @(negedge clk_ctrl);
        #1;
        n_checks++;
        if ({bus.m_psel, bus.m_penable, bus.m_pwrite, bus.rsp_valid, bus.rsp_err, bus.busy,
             bus.desc_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b need 0000000", {bus.m_psel, bus.m_penable,
                     bus.m_pwrite, bus.rsp_valid, bus.rsp_err, bus.busy, bus.desc_ready});
        end
        n_checks++;
        if (bus.m_paddr !== 12'h0 || bus.m_pwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr_data got %h/%h need 0/0", bus.m_paddr, bus.m_pwdata);
        end
        @(negedge clk_ctrl);
        rst_ctrl = 1'b0;
        #1;
        n_checks++;
        if (bus.desc_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got ready=%b busy=%b need 1/0", bus.desc_ready, bus.busy);
        end
    endtask

    task automatic test_insert();
        int n; bit got; int nwr = 0; int last;
        wait_states = 0; err_at = -1; status_dflt = 32'd0;
        status_q = {32'd0, 32'd1, 32'd1, 32'd2, 32'd0};
        cur_cmd = 2'd0; cur_stage = 5'd3; cur_tid = 16'h0042; cur_mask = '1;
        cur_aid = 16'($urandom); cur_params = {$urandom, $urandom, $urandom};
        cur_key = '0;
        for (int k = 15; k >= 0; k--) cur_key = {cur_key[KeyW-33:0], 32'hA000_0000 + 32'(k)};
        build_exp(); clear_logs();
        send_desc(n);
        wait_rsp(2000, got);
        repeat (3) @(negedge clk_ctrl);
        n_checks++;
        if (!got || n < 0) begin
            n_fail++; $display("FAIL insert_rsp got %0d need 1", got);
        end
        for (int i = 0; i < int'(NWr); i++) begin
            n_checks++;
            if (i >= log_addr.size() || log_write[i] !== 1'b1 || log_addr[i] !== exp_addr[i] ||
                log_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL insert_write[%0d] got %h/%h need %h/%h", i,
                         (i < log_addr.size()) ? log_addr[i] : 12'hx,
                         (i < log_data.size()) ? log_data[i] : 32'hx, exp_addr[i], exp_data[i]);
            end
        end
        foreach (log_write[i]) nwr += int'(log_write[i]);
        n_checks++;
        if (nwr != 40 || log_addr.size() != 45) begin
            n_fail++; $display("FAIL insert_counts got %0d/%0d need 40/45", nwr, log_addr.size());
        end
        n_checks++;
        if (log_setup.size() < 41 || log_setup[0] != n + 1 || log_setup[39] != n + 79 ||
            log_done[39] != n + 80 || log_setup[40] != n + 81) begin
            n_fail++;
            $display("FAIL insert_latency got first=%0d commit=%0d..%0d status=%0d need %0d",
                     log_setup[0] - n, log_setup[39] - n, log_done[39] - n, log_setup[40] - n, 1);
        end
        last = log_done.size() - 1;
        n_checks++;
        if (rsp_cyc.size() != 1 || rsp_errq[0] !== 1'b0 || rsp_cyc[0] != log_done[last] + 1) begin
            n_fail++; $display("FAIL insert_resp got n=%0d err=%b need 1/0", rsp_cyc.size(),
                               rsp_errq[0]);
        end
        n_checks++;
        if (unstable != 0 || overlap != 0) begin
            n_fail++; $display("FAIL insert_stable got %0d/%0d need 0/0", unstable, overlap);
        end
    endtask

    task automatic test_wait_states();
        int n; bit got; int bad = 0;
        wait_states = 3; err_at = -1;
        status_q = {32'd2, 32'd0};
        rand_desc(); build_exp(); clear_logs();
        send_desc(n);
        wait_rsp(4000, got);
        repeat (3) @(negedge clk_ctrl);
        for (int i = 0; i < int'(NWr); i++) begin
            n_checks++;
            if (i >= log_addr.size() || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i])
            begin
                n_fail++; $display("FAIL wait_write[%0d] got %h need %h/%h", i,
                                   (i < log_data.size()) ? log_data[i] : 32'hx, exp_addr[i],
                                   exp_data[i]);
            end
        end
        foreach (log_done[i]) if (log_done[i] - log_setup[i] != 4) bad++;
        n_checks++;
        if (bad != 0 || log_done.size() != 42) begin
            n_fail++; $display("FAIL wait_xfer_len got %0d bad of %0d need 0 of 42", bad,
                               log_done.size());
        end
        n_checks++;
        if (log_done.size() < 40 || log_done[39] != n + 200) begin
            n_fail++; $display("FAIL wait_commit got %0d need %0d", log_done[39] - n, 200);
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++; $display("FAIL wait_stable got %0d need 0", unstable);
        end
        n_checks++;
        if (!got || rsp_cyc.size() != 1 || rsp_errq[0] !== 1'b0) begin
            n_fail++; $display("FAIL wait_resp got %0d need 1 ok", rsp_cyc.size());
        end
        wait_states = 0;
    endtask

    task automatic test_pslverr();
        int n; bit got;
        err_at = 8; status_q.delete();
        rand_desc(); build_exp(); clear_logs();
        send_desc(n);
        wait_rsp(500, got);
        @(negedge clk_ctrl);
        #1;
        n_checks++;
        if (bus.desc_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL slverr_ready got %b need 1", bus.desc_ready);
        end
        repeat (10) @(negedge clk_ctrl);
        n_checks++;
        if (log_addr.size() != 9 || bus.m_psel !== 1'b0) begin
            n_fail++; $display("FAIL slverr_count got %0d need 9", log_addr.size());
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (i >= log_addr.size() || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i])
            begin
                n_fail++; $display("FAIL slverr_write[%0d] need %h/%h", i, exp_addr[i], exp_data[i]);
            end
        end
        n_checks++;
        if (!got || rsp_cyc.size() != 1 || rsp_errq[0] !== 1'b1 || log_done.size() < 9 ||
            rsp_cyc[0] != log_done[8] + 1) begin
            n_fail++; $display("FAIL slverr_resp got n=%0d err=%b need 1/1", rsp_cyc.size(),
                               rsp_errq[0]);
        end
        err_at = -1;
    endtask

    task automatic test_timeout();
        int n; bit got; int s;
        status_q.delete(); status_dflt = 32'd1;
        rand_desc(); build_exp(); clear_logs();
        send_desc(n);
        wait_rsp(1000, got);
        s = (log_setup.size() > 40) ? log_setup[40] : 0;
        n_checks++;
        if (!got || rsp_errq[0] !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err got %0d need err", got);
        end
        n_checks++;
        if (rsp_cyc.size() != 1 || rsp_cyc[0] < s + int'(Tmo) || rsp_cyc[0] > s + int'(Tmo) + 3)
        begin
            n_fail++; $display("FAIL timeout_window got %0d need %0d..%0d", rsp_cyc[0] - s, Tmo,
                               Tmo + 3);
        end
        status_dflt = 32'd0;
        // Error status from the TUE ends polling at once.
        status_q = {32'd0, 32'd1, 32'd3};
        rand_desc(); clear_logs();
        send_desc(n);
        wait_rsp(500, got);
        repeat (2) @(negedge clk_ctrl);
        n_checks++;
        if (!got || log_addr.size() != 43 || rsp_errq[0] !== 1'b1 ||
            rsp_cyc[0] != log_done[42] + 1) begin
            n_fail++; $display("FAIL status3 got xfers=%0d err=%b need 43/1", log_addr.size(),
                               rsp_errq[0]);
        end
    endtask

    task automatic test_handshake();
        int n; int n2; bit got = 1'b0; int bad = 0; int r1;
        status_q = {32'd1, 32'd1, 32'd0};
        rand_desc(); build_exp(); clear_logs();
        send_desc(n);
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk_ctrl);
            bus.desc_valid    = 1'b1;
            bus.desc_cmd      = 2'($urandom);
            bus.desc_table_id = 16'($urandom);
            bus.desc_key      = {16{$urandom}};
            #1;
            if (bus.desc_ready !== 1'b0) bad++;
            got = (bus.rsp_valid === 1'b1);
        end
        #2;
        n_checks++;
        if (!got || bad != 0) begin
            n_fail++; $display("FAIL hs_ready_busy got %0d ready cycles need 0", bad);
        end
        for (int i = 0; i < int'(NWr); i++) begin
            n_checks++;
            if (i >= log_addr.size() || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i])
            begin
                n_fail++; $display("FAIL hs_write1[%0d] need %h/%h", i, exp_addr[i], exp_data[i]);
            end
        end
        r1 = (rsp_cyc.size() != 0) ? rsp_cyc[0] : -10;
        status_q = {32'd2, 32'd0};
        rand_desc(); build_exp(); clear_logs();
        send_desc(n2);
        n_checks++;
        if (n2 != r1 + 1) begin
            n_fail++; $display("FAIL hs_accept2 got %0d need %0d", n2, r1 + 1);
        end
        wait_rsp(500, got);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= log_addr.size() || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i])
            begin
                n_fail++; $display("FAIL hs_write2[%0d] need %h/%h", i, exp_addr[i], exp_data[i]);
            end
        end
        n_checks++;
        if (!got || rsp_errq[0] !== 1'b0) begin
            n_fail++; $display("FAIL hs_resp2 got %0d need 1 ok", got);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit got;
        status_q.delete();
        rand_desc(); clear_logs();
        send_desc(n);
        for (int i = 0; i < 200 && xfer_n < 25; i++) @(negedge clk_ctrl);
        @(negedge clk_ctrl);
        rst_ctrl = 1'b1;
        #1;
        n_checks++;
        if (bus.m_psel !== 1'b0 || bus.m_penable !== 1'b0 || xfer_n < 25) begin
            n_fail++; $display("FAIL midrst_apb got psel=%b pen=%b need 0/0", bus.m_psel,
                               bus.m_penable);
        end
        repeat (3) @(negedge clk_ctrl);
        rst_ctrl = 1'b0;
        repeat (2) @(negedge clk_ctrl);
        n_checks++;
        if (rsp_cyc.size() != 0) begin
            n_fail++; $display("FAIL midrst_norsp got %0d need 0", rsp_cyc.size());
        end
        status_q = {32'd1, 32'd0};
        rand_desc(); build_exp(); clear_logs();
        send_desc(n);
        wait_rsp(500, got);
        for (int i = 0; i < int'(NWr); i++) begin
            n_checks++;
            if (i >= log_addr.size() || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i])
            begin
                n_fail++; $display("FAIL midrst_write[%0d] need %h/%h", i, exp_addr[i], exp_data[i]);
            end
        end
        n_checks++;
        if (!got || rsp_errq[0] !== 1'b0) begin
            n_fail++; $display("FAIL midrst_resp got %0d need 1 ok", got);
        end
    endtask

    initial begin
        bus.desc_valid         = 1'b0;
        bus.desc_cmd           = '0;
        bus.desc_stage         = '0;
        bus.desc_table_id      = '0;
        bus.desc_key           = '0;
        bus.desc_mask          = '0;
        bus.desc_action_id     = '0;
        bus.desc_action_params = '0;
        cur_key  = '0;
        cur_mask = '0;
        test_reset();
        test_insert();
        test_wait_states();
        test_pslverr();
        test_timeout();
        test_handshake();
        test_reset_mid();
        repeat (5) @(negedge clk_ctrl);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
